// File: rtl/pipelined_rv32_core.sv
// pipelined_rv32_core: five-stage in-order RV32 subset core (IF/ID/EX/MEM/WB)
// with private instruction memory, data memory and register file.
// Optional feature macro FORWARDING_EN: when defined, EX operands are forwarded
// from EX/MEM and MEM/WB and only load-use stalls. When undefined, the hazard
// unit stalls until every in-flight producer has reached WB.
module pipelined_rv32_core #(
   parameter int unsigned IMEM_WORDS = 256,
   parameter int unsigned DMEM_WORDS = 32
) (
   input logic clk_i,
   input logic rst_i,
   input logic start_i
);
   localparam int unsigned IW = $clog2(IMEM_WORDS);
   localparam int unsigned DW = $clog2(DMEM_WORDS);
   localparam logic [31:0] PC_MASK = 32'(IMEM_WORDS * 4) - 32'd1;

   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR, ALU_SLL, ALU_SRA, ALU_MUL
   } alu_op_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ifid_t;

   typedef struct packed {
      logic [31:0] rs1_val;
      logic [31:0] rs2_val;
      logic [31:0] imm;
`ifdef FORWARDING_EN
      logic [4:0]  rs1;
      logic [4:0]  rs2;
`endif
      logic [4:0]  rd;
      alu_op_e     alu_op;
      logic        alu_src_imm;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
   } idex_t;

   typedef struct packed {
      logic [31:0] alu_res;
      logic [31:0] store_data;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
   } exmem_t;

   typedef struct packed {
      logic [31:0] wb_data;
      logic [4:0]  rd;
      logic        reg_write;
   } memwb_t;

   // Storage: never reset, preloaded from outside.
   logic [31:0] imem   [IMEM_WORDS];
   logic [31:0] dmem_q [DMEM_WORDS];
   logic [31:0] rf_q   [32];

   logic [31:0] pc_q, pc_d;
   ifid_t       ifid_q, ifid_d;
   idex_t       idex_q, idex_d;
   exmem_t      exmem_q, exmem_d;
   memwb_t      memwb_q, memwb_d;

   logic [4:0]  id_rs1, id_rs2;
   logic [31:0] id_rs1_val, id_rs2_val;
   idex_t       id_out;
   logic        use_rs1, use_rs2, is_beq;
   logic        stall, flush;
   logic [31:0] br_target;
   logic [31:0] fwd_a, fwd_b, op_b;
   exmem_t      ex_out;
   memwb_t      mem_out;

   assign id_rs1 = ifid_q.instr[19:15];
   assign id_rs2 = ifid_q.instr[24:20];

   // Decode the IF/ID instruction into ID/EX control, immediate and source usage.
   always_comb begin : id_decode
      logic [31:0] ins;
      ins     = ifid_q.instr;
      id_out  = '0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      is_beq  = 1'b0;
      case (ins[6:0])
         7'b0110011: begin
            use_rs1          = 1'b1;
            use_rs2          = 1'b1;
            id_out.reg_write = 1'b1;
            case ({ins[31:25], ins[14:12]})
               {7'b0000000, 3'b111}: id_out.alu_op = ALU_AND;
               {7'b0000000, 3'b100}: id_out.alu_op = ALU_XOR;
               {7'b0000000, 3'b001}: id_out.alu_op = ALU_SLL;
               {7'b0000000, 3'b000}: id_out.alu_op = ALU_ADD;
               {7'b0100000, 3'b000}: id_out.alu_op = ALU_SUB;
               {7'b0000001, 3'b000}: id_out.alu_op = ALU_MUL;
               default: begin
                  use_rs1          = 1'b0;
                  use_rs2          = 1'b0;
                  id_out.reg_write = 1'b0;
               end
            endcase
         end
         7'b0010011: begin
            id_out.imm = {{20{ins[31]}}, ins[31:20]};
            if (ins[14:12] == 3'b000) begin
               use_rs1 = 1'b1;
               id_out.reg_write   = 1'b1;
               id_out.alu_src_imm = 1'b1;
               id_out.alu_op      = ALU_ADD;
            end else if (ins[14:12] == 3'b101 && ins[31:25] == 7'b0100000) begin
               use_rs1 = 1'b1;
               id_out.reg_write   = 1'b1;
               id_out.alu_src_imm = 1'b1;
               id_out.alu_op      = ALU_SRA;
            end
         end
         7'b0000011: begin
            if (ins[14:12] == 3'b010) begin
               use_rs1 = 1'b1;
               id_out.imm         = {{20{ins[31]}}, ins[31:20]};
               id_out.reg_write   = 1'b1;
               id_out.mem_read    = 1'b1;
               id_out.alu_src_imm = 1'b1;
            end
         end
         7'b0100011: begin
            if (ins[14:12] == 3'b010) begin
               use_rs1 = 1'b1;
               use_rs2 = 1'b1;
               id_out.imm         = {{20{ins[31]}}, ins[31:25], ins[11:7]};
               id_out.mem_write   = 1'b1;
               id_out.alu_src_imm = 1'b1;
            end
         end
         7'b1100011: begin
            if (ins[14:12] == 3'b000) begin
               use_rs1    = 1'b1;
               use_rs2    = 1'b1;
               is_beq     = 1'b1;
               id_out.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
         end
         default: ;
      endcase
      if (id_out.reg_write) id_out.rd = ins[11:7];
`ifdef FORWARDING_EN
      id_out.rs1 = id_rs1;
      id_out.rs2 = id_rs2;
`endif
      id_out.rs1_val = id_rs1_val;
      id_out.rs2_val = id_rs2_val;
   end

   // Register file read with x0 forced to zero and same-cycle WB bypass.
   always_comb begin : id_regread
      id_rs1_val = (id_rs1 == 5'd0) ? '0 : rf_q[id_rs1];
      id_rs2_val = (id_rs2 == 5'd0) ? '0 : rf_q[id_rs2];
      if (id_rs1 != 5'd0 && memwb_q.reg_write && memwb_q.rd == id_rs1) id_rs1_val = memwb_q.wb_data;
      if (id_rs2 != 5'd0 && memwb_q.reg_write && memwb_q.rd == id_rs2) id_rs2_val = memwb_q.wb_data;
   end

   // Hazard detection and ID-stage branch resolution; a stall suppresses the flush.
   always_comb begin : id_hazard
`ifdef FORWARDING_EN
      stall = idex_q.mem_read && (idex_q.rd != 5'd0) &&
              ((use_rs1 && idex_q.rd == id_rs1) || (use_rs2 && idex_q.rd == id_rs2));
`else
      stall = (use_rs1 && id_rs1 != 5'd0 &&
                ((idex_q.reg_write && idex_q.rd == id_rs1) ||
                 (exmem_q.reg_write && exmem_q.rd == id_rs1))) ||
              (use_rs2 && id_rs2 != 5'd0 &&
                ((idex_q.reg_write && idex_q.rd == id_rs2) ||
                 (exmem_q.reg_write && exmem_q.rd == id_rs2)));
`endif
      flush     = is_beq && (id_rs1_val == id_rs2_val) && !stall;
      br_target = (ifid_q.pc + id_out.imm) & PC_MASK;
   end

   // Execute: operand selection (with optional forwarding) and the ALU.
   always_comb begin : ex_stage
      fwd_a = idex_q.rs1_val;
      fwd_b = idex_q.rs2_val;
`ifdef FORWARDING_EN
      if (exmem_q.reg_write && exmem_q.rd != 5'd0 && exmem_q.rd == idex_q.rs1)
         fwd_a = exmem_q.alu_res;
      else if (memwb_q.reg_write && memwb_q.rd != 5'd0 && memwb_q.rd == idex_q.rs1)
         fwd_a = memwb_q.wb_data;
      if (exmem_q.reg_write && exmem_q.rd != 5'd0 && exmem_q.rd == idex_q.rs2)
         fwd_b = exmem_q.alu_res;
      else if (memwb_q.reg_write && memwb_q.rd != 5'd0 && memwb_q.rd == idex_q.rs2)
         fwd_b = memwb_q.wb_data;
`endif
      op_b   = idex_q.alu_src_imm ? idex_q.imm : fwd_b;
      ex_out = '0;
      case (idex_q.alu_op)
         ALU_ADD: ex_out.alu_res = fwd_a + op_b;
         ALU_SUB: ex_out.alu_res = fwd_a - op_b;
         ALU_AND: ex_out.alu_res = fwd_a & op_b;
         ALU_XOR: ex_out.alu_res = fwd_a ^ op_b;
         ALU_SLL: ex_out.alu_res = fwd_a << op_b[4:0];
         ALU_SRA: ex_out.alu_res = $signed(fwd_a) >>> op_b[4:0];
         ALU_MUL: ex_out.alu_res = fwd_a * op_b;
         default: ex_out.alu_res = '0;
      endcase
      ex_out.store_data = fwd_b;
      ex_out.rd         = idex_q.rd;
      ex_out.reg_write  = idex_q.reg_write;
      ex_out.mem_read   = idex_q.mem_read;
      ex_out.mem_write  = idex_q.mem_write;
   end

   // Memory stage: combinational load data select into the write-back value.
   always_comb begin : mem_stage
      mem_out.wb_data   = exmem_q.mem_read ? dmem_q[exmem_q.alu_res[DW+1:2]] : exmem_q.alu_res;
      mem_out.rd        = exmem_q.rd;
      mem_out.reg_write = exmem_q.reg_write;
   end

   // Next-state for PC and pipeline registers: start_i=0 freezes everything.
   always_comb begin : next_state
      pc_d    = pc_q;
      ifid_d  = ifid_q;
      idex_d  = idex_q;
      exmem_d = exmem_q;
      memwb_d = memwb_q;
      if (start_i) begin
         exmem_d = ex_out;
         memwb_d = mem_out;
         if (stall) begin
            idex_d = '0;
         end else begin
            idex_d = id_out;
            if (flush) begin
               pc_d   = br_target;
               ifid_d = '0;
            end else begin
               pc_d         = (pc_q + 32'd4) & PC_MASK;
               ifid_d.pc    = pc_q;
               ifid_d.instr = imem[pc_q[IW+1:2]];
            end
         end
      end
   end

   // PC and pipeline registers with synchronous active-low reset to a bubble.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         pc_q    <= '0;
         ifid_q  <= '0;
         idex_q  <= '0;
         exmem_q <= '0;
         memwb_q <= '0;
      end else begin
         pc_q    <= pc_d;
         ifid_q  <= ifid_d;
         idex_q  <= idex_d;
         exmem_q <= exmem_d;
         memwb_q <= memwb_d;
      end
   end

   // Architectural writes: register file from WB, data memory from MEM.
   always_ff @(posedge clk_i) begin
      if (rst_i && start_i) begin
         if (memwb_q.reg_write && memwb_q.rd != 5'd0) rf_q[memwb_q.rd] <= memwb_q.wb_data;
         if (exmem_q.mem_write) dmem_q[exmem_q.alu_res[DW+1:2]] <= exmem_q.store_data;
      end
   end

endmodule

// File: tb/tb_pipelined_rv32_core.sv
// Directed testbench for pipelined_rv32_core: hand-assembled programs,
// hierarchical preload of memories/registers, hand-computed expectations.
module tb_pipelined_rv32_core;
   logic clk_i   = 1'b0;
   logic rst_i   = 1'b0;
   logic start_i = 1'b0;
   int checks      = 0;
   int failures    = 0;
   int stall_total = 0;
   int flush_total = 0;
   int sbase;
   int fbase;

   always #5 clk_i = ~clk_i;

   pipelined_rv32_core #(.IMEM_WORDS(256), .DMEM_WORDS(32)) dut (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .start_i(start_i)
   );

   // Count stall/flush cycles that will take effect at the next rising edge.
   always @(negedge clk_i) begin
      if (rst_i && start_i && dut.stall) stall_total++;
      if (rst_i && start_i && dut.flush) flush_total++;
   end

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
      return {off[12], off[10:5], rs2, rs1, 3'b000, off[4:1], off[11], 7'b1100011};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic clear_imem();
      for (int i = 0; i < 256; i++) dut.imem[i] = '0;
   endtask

   // Hold reset for two cycles, check the bubble state, then release with start=1.
   task automatic do_reset(input string tag);
      start_i = 1'b0;
      rst_i   = 1'b0;
      cyc(2);
      check({tag, "_rst_pc"}, dut.pc_q, 32'd0);
      check({tag, "_rst_ifid"}, 32'(dut.ifid_q == '0), 32'd1);
      check({tag, "_rst_idex"}, 32'(dut.idex_q == '0), 32'd1);
      check({tag, "_rst_exmem"}, 32'(dut.exmem_q == '0), 32'd1);
      check({tag, "_rst_memwb"}, 32'(dut.memwb_q == '0), 32'd1);
      rst_i   = 1'b1;
      start_i = 1'b1;
      sbase   = stall_total;
      fbase   = flush_total;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) dut.rf_q[i] = '0;
      for (int i = 0; i < 32; i++) dut.dmem_q[i] = '0;
      #1;

      // ALU chain plus and/x0 handling; PC sequence after reset.
      clear_imem();
      dut.rf_q[13] = 32'h0000_DEAD;
      dut.imem[0] = enc_i(12'd10, 5'd0, 3'b000, 5'd1, 7'b0010011);
      dut.imem[1] = enc_i(12'hFFD, 5'd1, 3'b000, 5'd2, 7'b0010011);
      dut.imem[2] = enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3);
      dut.imem[3] = enc_r(7'b0000001, 5'd2, 5'd2, 3'b000, 5'd4);
      dut.imem[4] = enc_r(7'b0000000, 5'd2, 5'd1, 3'b100, 5'd5);
      dut.imem[5] = enc_r(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd12);
      dut.imem[6] = enc_i(12'd5, 5'd0, 3'b000, 5'd0, 7'b0010011);
      dut.imem[7] = enc_r(7'b0000000, 5'd0, 5'd0, 3'b000, 5'd13);
      do_reset("alu");
      check("pc_c0", dut.pc_q, 32'd0);
      cyc(1);
      check("pc_c1", dut.pc_q, 32'd4);
      cyc(1);
      check("pc_c2", dut.pc_q, 32'd8);
      cyc(30);
      check("alu_x1", dut.rf_q[1], 32'd10);
      check("alu_x2", dut.rf_q[2], 32'd7);
      check("alu_x3", dut.rf_q[3], 32'd3);
      check("alu_x4", dut.rf_q[4], 32'd49);
      check("alu_x5", dut.rf_q[5], 32'd13);
      check("alu_and_x12", dut.rf_q[12], 32'd2);
      check("alu_x0", dut.rf_q[0], 32'd0);
      check("alu_x13", dut.rf_q[13], 32'd0);
`ifdef FORWARDING_EN
      check("alu_stalls", 32'(stall_total - sbase), 32'd0);
`endif

      // Shifts.
      clear_imem();
      dut.imem[0] = enc_i(12'd1, 5'd0, 3'b000, 5'd1, 7'b0010011);
      dut.imem[1] = enc_i(12'hFF0, 5'd0, 3'b000, 5'd6, 7'b0010011);
      dut.imem[2] = enc_i(12'h402, 5'd6, 3'b101, 5'd7, 7'b0010011);
      dut.imem[3] = enc_r(7'b0000000, 5'd1, 5'd7, 3'b001, 5'd8);
      do_reset("shift");
      cyc(30);
      check("shift_x6", dut.rf_q[6], 32'hFFFF_FFF0);
      check("shift_x7", dut.rf_q[7], 32'hFFFF_FFFC);
      check("shift_x8", dut.rf_q[8], 32'hFFFF_FFF8);

      // Load-use hazard.
      clear_imem();
      dut.dmem_q[0] = 32'd5;
      dut.rf_q[1]   = '0;
      dut.rf_q[2]   = '0;
      dut.imem[0] = enc_i(12'd0, 5'd0, 3'b010, 5'd1, 7'b0000011);
      dut.imem[1] = enc_r(7'b0000000, 5'd1, 5'd1, 3'b000, 5'd2);
      do_reset("ldu");
      cyc(20);
      check("ldu_x1", dut.rf_q[1], 32'd5);
      check("ldu_x2", dut.rf_q[2], 32'd10);
`ifdef FORWARDING_EN
      check("ldu_stalls", 32'(stall_total - sbase), 32'd1);
`else
      check("ldu_stalls", 32'(stall_total - sbase), 32'd2);
`endif

      // Store, reload, and data-memory address wrap (132 -> word 1).
      clear_imem();
      dut.dmem_q[1] = '0;
      dut.dmem_q[2] = '0;
      dut.rf_q[10]  = '0;
      dut.imem[0] = enc_i(12'd42, 5'd0, 3'b000, 5'd9, 7'b0010011);
      dut.imem[1] = enc_s(12'd8, 5'd9, 5'd0);
      dut.imem[2] = enc_i(12'd8, 5'd0, 3'b010, 5'd10, 7'b0000011);
      dut.imem[3] = enc_s(12'd132, 5'd9, 5'd0);
      do_reset("st");
      cyc(25);
      check("st_dmem2", dut.dmem_q[2], 32'd42);
      check("st_x10", dut.rf_q[10], 32'd42);
      check("st_wrap_dmem1", dut.dmem_q[1], 32'd42);

      // Branches: taken beq skips one instruction, not-taken beq falls through.
      clear_imem();
      dut.rf_q[11] = '0;
      dut.rf_q[14] = '0;
      dut.rf_q[15] = 32'd3;
      dut.rf_q[17] = '0;
      dut.imem[0] = enc_b(13'd8, 5'd0, 5'd0);
      dut.imem[1] = enc_i(12'd1, 5'd0, 3'b000, 5'd11, 7'b0010011);
      dut.imem[2] = enc_i(12'd7, 5'd0, 3'b000, 5'd14, 7'b0010011);
      dut.imem[3] = enc_b(13'd8, 5'd0, 5'd15);
      dut.imem[4] = enc_i(12'd5, 5'd0, 3'b000, 5'd17, 7'b0010011);
      do_reset("br");
      cyc(1);
      check("br_pc_c1", dut.pc_q, 32'd4);
      check("br_flush_taken", 32'(dut.flush), 32'd1);
      cyc(1);
      check("br_pc_target", dut.pc_q, 32'd8);
      check("br_flush_cnt", 32'(flush_total - fbase), 32'd1);
      cyc(2);
      check("br_pc_c4", dut.pc_q, 32'd16);
      check("br_flush_nt", 32'(dut.flush), 32'd0);
      cyc(1);
      check("br_pc_nt", dut.pc_q, 32'd20);
      cyc(20);
      check("br_pc_c25", dut.pc_q, 32'd100);
      check("br_x11", dut.rf_q[11], 32'd0);
      check("br_x14", dut.rf_q[14], 32'd7);
      check("br_x17", dut.rf_q[17], 32'd5);
      check("br_flush_total", 32'(flush_total - fbase), 32'd1);
      check("br_stalls", 32'(stall_total - sbase), 32'd0);

      // start_i=0 freezes the PC; then run on to the PC wrap.
      start_i = 1'b0;
      cyc(3);
      check("hold_pc", dut.pc_q, 32'd100);
      start_i = 1'b1;
      cyc(1);
      check("resume_pc", dut.pc_q, 32'd104);
      cyc(230);
      check("wrap_pc", dut.pc_q, 32'd0);
      cyc(1);
      check("wrap_pc_next", dut.pc_q, 32'd4);

      // Mid-run reset restarts from PC 0 with bubbles.
      do_reset("mid");
      cyc(1);
      check("mid_pc_c1", dut.pc_q, 32'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
